// File: rtl/obi_sram_slave.sv
// rtl/obi_sram_slave.sv - OBI req/gnt/rvalid data-memory responder in front of a synchronous SRAM macro
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset
//   req_i/gnt_o   OBI request / grant (grant after GNT_WAIT held cycles)
//   addr_i        byte address, bits [1:0] ignored
//   we_i, be_i    write flag and byte enables
//   wdata_i       write data
//   rvalid_o      one response per granted request, LATENCY cycles after grant
//   rdata_o       read data, zero for writes and error responses
//   err_o         out-of-range response flag, qualified by rvalid_o
//   sram_*        single-port SRAM macro access (combinational in the grant cycle)
module obi_sram_slave #(
   parameter int          SRAM_AW   = 10,
   parameter int          LATENCY   = 1,
   parameter int          GNT_WAIT  = 0,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               req_i,
   output logic               gnt_o,
   input  logic [31:0]        addr_i,
   input  logic               we_i,
   input  logic [3:0]         be_i,
   input  logic [31:0]        wdata_i,
   output logic               rvalid_o,
   output logic [31:0]        rdata_o,
   output logic               err_o,
   output logic               sram_en_o,
   output logic [3:0]         sram_we_o,
   output logic [SRAM_AW-1:0] sram_addr_o,
   output logic [31:0]        sram_wdata_o,
   input  logic [31:0]        sram_rdata_i
);

   logic [2:0]         wait_cnt;
   logic [31:0]        offset;
   logic               in_range;
   logic               handshake;
   logic [LATENCY-1:0] pipe_valid;
   logic [LATENCY-1:0] pipe_read;
   logic [LATENCY-1:0] pipe_err;

   // Unsigned subtraction: addresses below the base wrap to huge offsets
   // and fall out of range without a separate lower-bound compare.
   assign offset    = addr_i - BASE_ADDR;
   assign in_range  = (offset >> (SRAM_AW + 2)) == 32'd0;

   assign gnt_o     = req_i && !rst_i && (wait_cnt == 3'(GNT_WAIT));
   assign handshake = req_i && gnt_o;

   always_ff @(posedge clk_i) begin
      if (rst_i || !req_i || gnt_o) begin
         wait_cnt <= 3'd0;
      end else begin
         wait_cnt <= wait_cnt + 3'd1;
      end
   end

   always_comb begin
      sram_en_o    = 1'b0;
      sram_we_o    = 4'b0000;
      sram_addr_o  = offset[SRAM_AW+1:2];
      sram_wdata_o = wdata_i;
      if (handshake && in_range) begin
         sram_en_o = 1'b1;
         sram_we_o = we_i ? be_i : 4'b0000;
      end
   end

   // Response tags travel alongside the SRAM read latency so the tail
   // lines up with sram_rdata_i for reads.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pipe_valid <= '0;
         pipe_read  <= '0;
         pipe_err   <= '0;
      end else begin
         pipe_valid[0] <= handshake;
         pipe_read[0]  <= !we_i;
         pipe_err[0]   <= !in_range;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_read[i]  <= pipe_read[i-1];
            pipe_err[i]   <= pipe_err[i-1];
         end
      end
   end

   assign rvalid_o = pipe_valid[LATENCY-1];
   assign err_o    = pipe_valid[LATENCY-1] && pipe_err[LATENCY-1];
   assign rdata_o  = (pipe_valid[LATENCY-1] && pipe_read[LATENCY-1] && !pipe_err[LATENCY-1])
                     ? sram_rdata_i : 32'd0;

endmodule

// File: tb/tb_obi_sram_slave.sv
// tb/tb_obi_sram_slave.sv - self-checking bench for obi_sram_slave
module tb_obi_sram_slave;

   logic        clk = 1'b0;
   logic        rst;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   logic        req [3];
   logic        we [3];
   logic [3:0]  be [3];
   logic [31:0] addr [3];
   logic [31:0] wdata [3];
   logic        gnt [3];
   logic        rvalid [3];
   logic        err [3];
   logic [31:0] rdata [3];
   logic        sram_en [3];
   logic [3:0]  sram_we [3];
   logic [9:0]  sram_addr [3];
   logic [31:0] sram_wdata [3];
   logic [31:0] sram_rdata [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(int i);
      return (i == 0) ? 1 : ((i == 1) ? 3 : 2);
   endfunction
   function automatic int gw_of(int i);
      return (i == 2) ? 2 : 0;
   endfunction
   function automatic logic [31:0] base_of(int i);
      return (i == 1) ? 32'h8000_0000 : 32'h0000_0000;
   endfunction

   // Three configurations, each with its own SRAM macro model.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int          LAT  = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
      localparam int          GW   = (g == 2) ? 2 : 0;
      localparam logic [31:0] BASE = (g == 1) ? 32'h8000_0000 : 32'h0000_0000;
      logic [31:0] mem [1024];
      logic [31:0] pipe [LAT];

      initial begin
         for (int k = 0; k < 1024; k++) mem[k] = 32'd0;
         for (int k = 0; k < LAT; k++) pipe[k] = 32'd0;
      end

      obi_sram_slave #(.SRAM_AW(10), .LATENCY(LAT), .GNT_WAIT(GW), .BASE_ADDR(BASE)) u_dut (
         .clk_i(clk), .rst_i(rst), .req_i(req[g]), .gnt_o(gnt[g]), .addr_i(addr[g]),
         .we_i(we[g]), .be_i(be[g]), .wdata_i(wdata[g]), .rvalid_o(rvalid[g]),
         .rdata_o(rdata[g]), .err_o(err[g]), .sram_en_o(sram_en[g]), .sram_we_o(sram_we[g]),
         .sram_addr_o(sram_addr[g]), .sram_wdata_o(sram_wdata[g]), .sram_rdata_i(sram_rdata[g])
      );

      always @(posedge clk) begin
         if (sram_en[g]) begin
            for (int b = 0; b < 4; b++)
               if (sram_we[g][b]) mem[sram_addr[g]][8*b +: 8] <= sram_wdata[g][8*b +: 8];
            pipe[0] <= mem[sram_addr[g]];
         end
         for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
      assign sram_rdata[g] = pipe[LAT-1];
   end

   typedef struct {
      int          inst;
      int          due;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   typedef struct {
      int          inst;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   exp_t        expq [$];
   logic [31:0] model_mem [3][1024];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one request (caller is 1 time unit past a rising edge), wait for
   // the grant, predict the response and return just after the handshake edge
   // with req still high so the next call is back-to-back.
   task automatic issue(int i, logic [31:0] a, logic w, logic [3:0] b, logic [31:0] d,
                        bit use_tab, logic [31:0] trd, logic terr, bit push);
      int          waits;
      logic        inr;
      int          wi;
      logic [31:0] off;
      exp_t        e;
      waits = 0;
      req[i] = 1'b1; addr[i] = a; we[i] = w; be[i] = b; wdata[i] = d;
      #1;
      while (gnt[i] !== 1'b1 && waits < 20) begin
         @(posedge clk);
         #2;
         waits++;
      end
      if (gnt[i] !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL gnt_timeout: inst %0d no grant within %0d cycles", i, waits);
         req[i] = 1'b0;
         step();
         return;
      end
      check("gnt_wait", waits, gw_of(i));
      off = a - base_of(i);
      inr = off < 32'd4096;
      wi  = int'(off / 4) % 1024;
      check("sram_en", sram_en[i], inr);
      check("sram_we", sram_we[i], (inr && w) ? b : 4'b0000);
      if (inr) check("sram_addr", sram_addr[i], wi);
      e.inst = i;
      e.due  = cyc + lat_of(i);
      if (use_tab) begin
         e.rdata = trd;
         e.err   = terr;
      end else begin
         e.rdata = (inr && !w) ? model_mem[i][wi] : 32'd0;
         e.err   = !inr;
      end
      if (inr && w)
         for (int k = 0; k < 4; k++)
            if (b[k]) model_mem[i][wi][8*k +: 8] = d[8*k +: 8];
      if (push) expq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int i);
      req[i] = 1'b0;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   vec_t        vecs [$];
   logic [31:0] ra;
   logic        gpat [6];

   initial begin
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'h0; addr[i] = 32'd0; wdata[i] = 32'd0;
         for (int k = 0; k < 1024; k++) model_mem[i][k] = 32'd0;
      end
      rst = 1'b1;

      // Response monitor: every rvalid must match the oldest prediction, on its cycle.
      fork
         forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
               if (rvalid[i] === 1'b1) begin
                  if (expq.size() == 0 || expq[0].inst != i) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_rvalid: inst %0d cycle %0d", i, cyc);
                  end else begin
                     e = expq.pop_front();
                     check("resp_cycle", cyc, e.due);
                     check("rdata", rdata[i], e.rdata);
                     check("err", err[i], e.err);
                  end
               end
            end
         end
      join_none

      // Reset state, with requests asserted during reset.
      step();
      step();
      for (int i = 0; i < 3; i++) req[i] = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("rst_gnt", gnt[i], 1'b0);
         check("rst_rvalid", rvalid[i], 1'b0);
         check("rst_err", err[i], 1'b0);
         check("rst_rdata", rdata[i], 32'd0);
         check("rst_sram_en", sram_en[i], 1'b0);
         check("rst_sram_we", sram_we[i], 4'b0000);
      end
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) req[i] = 1'b0;
      step();

      // Directed vectors, back-to-back within each instance.
      vecs = '{
         '{0, 32'h0000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0,         1'b0},
         '{0, 32'h0000_0010, 1'b0, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0},
         '{0, 32'h0000_0020, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b0},
         '{0, 32'h0000_0020, 1'b1, 4'h5, 32'h1122_3344, 32'h0,         1'b0},
         '{0, 32'h0000_0020, 1'b0, 4'hF, 32'h0,         32'hFF22_FF44, 1'b0},
         '{0, 32'h0000_0020, 1'b1, 4'h0, 32'hAAAA_AAAA, 32'h0,         1'b0},
         '{0, 32'h0000_0020, 0, 4'hF, 32'h0,            32'hFF22_FF44, 1'b0},
         '{0, 32'h0000_1000, 1'b0, 4'hF, 32'h0,         32'h0,         1'b1},
         '{0, 32'h0000_1000, 1'b1, 4'hF, 32'h1234_5678, 32'h0,         1'b1},
         '{0, 32'h0000_0FFC, 1'b1, 4'hF, 32'hCAFE_F00D, 32'h0,         1'b0},
         '{0, 32'h0000_0FFC, 1'b0, 4'hF, 32'h0,         32'hCAFE_F00D, 1'b0},
         '{1, 32'h7FFF_FFFC, 1'b0, 4'hF, 32'h0,         32'h0,         1'b1},
         '{1, 32'h8000_1000, 1'b0, 4'hF, 32'h0,         32'h0,         1'b1},
         '{1, 32'h8000_0004, 1'b1, 4'hF, 32'h5A5A_5A5A, 32'h0,         1'b0},
         '{1, 32'h8000_0004, 1'b0, 4'hF, 32'h0,         32'h5A5A_5A5A, 1'b0}
      };
      for (int k = 0; k < vecs.size(); k++) begin
         if (k > 0 && vecs[k-1].inst != vecs[k].inst) idle(vecs[k-1].inst);
         issue(vecs[k].inst, vecs[k].addr, vecs[k].we, vecs[k].be, vecs[k].wdata,
               1'b1, vecs[k].exp_rdata, vecs[k].exp_err, 1'b1);
      end
      idle(1);
      repeat (6) step();

      // LATENCY=3: preload words 0..3, then four back-to-back reads.
      for (int k = 0; k < 4; k++)
         issue(1, 32'h8000_0000 + 32'(4*k), 1'b1, 4'hF, 32'(k), 1'b0, 32'h0, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++)
         issue(1, 32'h8000_0000 + 32'(4*k), 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      idle(1);
      repeat (6) step();

      // GNT_WAIT=2: request held continuously -> grants at cycles 2 and 5.
      gpat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      req[2] = 1'b1; addr[2] = 32'h0000_0000; we[2] = 1'b0; be[2] = 4'hF;
      for (int k = 0; k < 6; k++) begin
         #1;
         check("gw2_gnt_pattern", gnt[2], gpat[k]);
         if (gnt[2] === 1'b1) begin
            e.inst = 2; e.due = cyc + 2; e.rdata = model_mem[2][0]; e.err = 1'b0;
            expq.push_back(e);
         end
         @(posedge clk);
         #1;
      end
      idle(2);
      repeat (6) step();

      // Reset one cycle after a LATENCY=3 read grant: the response is dropped.
      issue(1, 32'h8000_0008, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (k == 2) begin
            rst = 1'b0;
            req[1] = 1'b0;
         end
         #1;
         check("rst_flight_rvalid", rvalid[1], 1'b0);
         if (k < 2) check("rst_flight_gnt", gnt[1], 1'b0);
         @(posedge clk);
         #1;
      end
      issue(1, 32'h8000_0008, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      idle(1);
      repeat (6) step();

      // Randomized traffic against the reference model.
      for (int i = 0; i < 3; i += 2) begin
         for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) idle(i);
            if ($urandom_range(0, 7) == 0)
               ra = base_of(i) + 32'h1000 + ($urandom_range(0, 255) << 2);
            else
               ra = base_of(i) + ($urandom_range(0, 31) << 2) + 32'($urandom_range(0, 3));
            issue(i, ra, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                  1'b0, 32'h0, 1'b0, 1'b1);
         end
         idle(i);
         repeat (6) step();
      end

      check("responses_outstanding", expq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
